// File: rtl/pid_pkg.sv
// Shared defaults for the balance-loop PID controller and its helpers.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package pid_pkg;

    localparam int PID_IN_W     = 16;
    localparam int PID_ERR_W    = 10;
    localparam int PID_OUT_W    = 12;
    localparam int PID_P_COEFF  = 13;
    localparam int PID_I_W      = 18;
    localparam int PID_I_SHIFT  = 6;
    localparam int PID_D_SHIFT  = 6;
    localparam bit PID_AW_EN    = 1'b1;
    localparam int PID_SS_W     = 8;
    localparam int PID_SS_PRE_W = 19;

    // Internal sum width: four guard bits over the output word are enough to
    // hold P + I + D for the supported gain and shift ranges without overflow.
    function automatic int sum_width(input int out_w);
        return out_w + 4;
    endfunction

endpackage

// File: rtl/sat_signed.sv
// Signed clamp of an IN_W value into the OUT_W two's-complement range.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i (signed input), y_o (clamped result), sat_o (clamp was active).
module sat_signed #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  a_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // In range exactly when every bit from the output sign bit upward
            // agrees with the input sign bit.
            logic in_range;
            assign in_range = (&a_i[IN_W-1:OUT_W-1]) || ~(|a_i[IN_W-1:OUT_W-1]);
            assign sat_o    = ~in_range;
            assign y_o      = in_range      ? a_i[OUT_W-1:0] :
                              a_i[IN_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                              {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_wide
            assign y_o   = OUT_W'(a_i);
            assign sat_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pid_ctrl_gen.sv
// Saturated P+I+D control word from pitch / pitch rate, with soft-start timer.
// Latency: 1 clock from inputs to PID_cntrl / pid_sat; no comb in->out path.
// Backpressure: none; vld qualifies integrator accumulation only.
// Ports: clk/rst (sync, active-high), vld, ptch, ptch_rt, pwr_up, rider_off in;
//        PID_cntrl, pid_sat, ss_tmr out (all registered).
module pid_ctrl_gen
    import pid_pkg::*;
#(
    parameter int IN_W     = PID_IN_W,
    parameter int ERR_W    = PID_ERR_W,
    parameter int OUT_W    = PID_OUT_W,
    parameter int P_COEFF  = PID_P_COEFF,
    parameter int I_W      = PID_I_W,
    parameter int I_SHIFT  = PID_I_SHIFT,
    parameter int D_SHIFT  = PID_D_SHIFT,
    parameter bit AW_EN    = PID_AW_EN,
    parameter int SS_W     = PID_SS_W,
    parameter int SS_PRE_W = PID_SS_PRE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic signed [IN_W-1:0]  ptch,
    input  logic signed [IN_W-1:0]  ptch_rt,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                    pid_sat,
    output logic [SS_W-1:0]         ss_tmr
);

    localparam int SUM_W  = sum_width(OUT_W);
    // Gain is at most 5 bits; one extra bit keeps it positive as a signed operand.
    localparam int PROD_W = ERR_W + 6;
    localparam logic signed [5:0] P_K = 6'(P_COEFF);

    logic signed [ERR_W-1:0] err_sat;
    logic                    err_clamp_unused;
    logic signed [SUM_W-1:0] sum;
    logic signed [OUT_W-1:0] pid_d, pid_q;
    logic                    sat_d, sat_q;
    logic signed [I_W:0]     integ_acc;
    logic signed [I_W-1:0]   integ_acc_sat;
    logic                    integ_clamp_unused;
    logic signed [I_W-1:0]   integ_d, integ_q;
    logic [SS_PRE_W-1:0]     pre_d, pre_q;
    logic [SS_W-1:0]         ss_d, ss_q;

    sat_signed #(.IN_W(IN_W), .OUT_W(ERR_W)) u_err_sat (
        .a_i   (ptch),
        .y_o   (err_sat),
        .sat_o (err_clamp_unused)
    );

    // D term is the negated, shifted rate; I term uses the integrator value
    // held before this edge.
    assign sum = SUM_W'(PROD_W'(err_sat) * PROD_W'(P_K))
               + SUM_W'(integ_q >>> I_SHIFT)
               - SUM_W'(ptch_rt >>> D_SHIFT);

    sat_signed #(.IN_W(SUM_W), .OUT_W(OUT_W)) u_out_sat (
        .a_i   (sum),
        .y_o   (pid_d),
        .sat_o (sat_d)
    );

    // One guard bit so the accumulate never wraps before clamping.
    assign integ_acc = (I_W+1)'(integ_q) + (I_W+1)'(err_sat);

    sat_signed #(.IN_W(I_W+1), .OUT_W(I_W)) u_integ_sat (
        .a_i   (integ_acc),
        .y_o   (integ_acc_sat),
        .sat_o (integ_clamp_unused)
    );

    always_comb begin
        integ_d = integ_q;
        if (rider_off) begin
            integ_d = '0;
        end else if (!vld) begin
            integ_d = integ_q;
        end else if (AW_EN && sat_d && (err_sat[ERR_W-1] == sum[SUM_W-1])) begin
            // Output already pinned and the error pushes further the same way:
            // accumulating would only wind the integrator up.
            integ_d = integ_q;
        end else begin
            integ_d = integ_acc_sat;
        end
    end

    // Soft-start: free-running prescaler while powered; the timer steps on
    // prescaler wrap and sticks at all-ones.
    always_comb begin
        pre_d = pre_q;
        ss_d  = ss_q;
        if (!pwr_up) begin
            pre_d = '0;
            ss_d  = '0;
        end else begin
            pre_d = pre_q + SS_PRE_W'(1);
            if ((&pre_q) && !(&ss_q)) begin
                ss_d = ss_q + SS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q   <= '0;
            sat_q   <= 1'b0;
            integ_q <= '0;
            pre_q   <= '0;
            ss_q    <= '0;
        end else begin
            pid_q   <= pid_d;
            sat_q   <= sat_d;
            integ_q <= integ_d;
            pre_q   <= pre_d;
            ss_q    <= ss_d;
        end
    end

    assign PID_cntrl = pid_q;
    assign pid_sat   = sat_q;
    assign ss_tmr    = ss_q;

endmodule

// File: tb/tb_pid_ctrl_gen.sv
module tb_pid_ctrl_gen;

    localparam int SS_PRE = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               vld = 1'b0;
    logic signed [15:0] ptch = '0;
    logic signed [15:0] ptch_rt = '0;
    logic               pwr_up = 1'b0;
    logic               rider_off = 1'b0;

    logic signed [11:0] pid_aw, pid_pl;
    logic               sat_aw, sat_pl;
    logic [7:0]         ss_aw, ss_pl;

    int errors = 0;
    int checks = 0;

    // Reference state: index 0 = anti-windup instance, 1 = plain instance.
    int m_integ [2];
    int m_pid   [2];
    bit m_sat   [2];
    int m_on;           // clocks spent with pwr_up high since last clear

    always #5 clk = ~clk;

    pid_ctrl_gen #(.AW_EN(1'b1), .SS_PRE_W(SS_PRE)) dut_aw (
        .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off),
        .PID_cntrl(pid_aw), .pid_sat(sat_aw), .ss_tmr(ss_aw)
    );

    pid_ctrl_gen #(.AW_EN(1'b0), .SS_PRE_W(SS_PRE)) dut_pl (
        .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off),
        .PID_cntrl(pid_pl), .pid_sat(sat_pl), .ss_tmr(ss_pl)
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int exp_ss();
        return clampi(m_on / (1 << SS_PRE), 0, 255);
    endfunction

    // Advance the reference by one clock using the current inputs, then let
    // the DUT take the same edge and settle.
    task automatic step();
        int e, sum, d;
        int n_integ [2];
        int n_pid   [2];
        bit n_sat   [2];
        e = clampi(int'(ptch), -512, 511);
        d = -(int'(ptch_rt) >>> 6);
        for (int k = 0; k < 2; k++) begin
            sum = e * 13 + (m_integ[k] >>> 6) + d;
            n_pid[k] = clampi(sum, -2048, 2047);
            n_sat[k] = (n_pid[k] != sum);
            if (rider_off)
                n_integ[k] = 0;
            else if (!vld)
                n_integ[k] = m_integ[k];
            else if (k == 0 && n_sat[k] && ((e < 0) == (sum < 0)))
                n_integ[k] = m_integ[k];
            else
                n_integ[k] = clampi(m_integ[k] + e, -131072, 131071);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_integ[k] = rst ? 0 : n_integ[k];
            m_pid[k]   = rst ? 0 : n_pid[k];
            m_sat[k]   = rst ? 1'b0 : n_sat[k];
        end
        m_on = (rst || !pwr_up) ? 0 : m_on + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0; rider_off = 1'b0;
        step();
        step();
        checks++;
        if (pid_aw !== 12'h000 || pid_pl !== 12'h000 || sat_aw !== 1'b0 || sat_pl !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: pid=%h/%h sat=%b/%b, want 000/000 0/0", pid_aw, pid_pl, sat_aw, sat_pl);
        end
        checks++;
        if (ss_aw !== 8'h00 || dut_aw.integ_q !== 18'sd0 || dut_pl.integ_q !== 18'sd0) begin
            errors++;
            $display("FAIL reset_state: ss=%h integ=%0d/%0d, want 00 0/0", ss_aw, dut_aw.integ_q, dut_pl.integ_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            checks++;
            if (ss_aw !== 8'h00 || ss_pl !== 8'h00) begin
                errors++;
                $display("FAIL ss_idle: cyc %0d ss=%h/%h, want 00", i, ss_aw, ss_pl);
            end
        end
    endtask

    task automatic test_p_d();
        rider_off = 1'b1; ptch = 16'sh0002; ptch_rt = '0;
        step();
        checks++;
        if (pid_aw !== 12'h01A || pid_pl !== 12'h01A || sat_aw !== 1'b0) begin
            errors++;
            $display("FAIL p_term: pid=%h/%h sat=%b, want 01A 0", pid_aw, pid_pl, sat_aw);
        end
        ptch = '0; ptch_rt = 16'sh0100;
        step();
        checks++;
        if (pid_aw !== 12'hFFC || pid_pl !== 12'hFFC) begin
            errors++;
            $display("FAIL d_term: pid=%h/%h, want FFC", pid_aw, pid_pl);
        end
        ptch = -16'sd300; ptch_rt = -16'sd1000;
        step();
        checks++;
        if (pid_aw !== 12'(m_pid[0]) || pid_pl !== 12'(m_pid[1])) begin
            errors++;
            $display("FAIL pd_neg: pid=%h/%h, want %h", pid_aw, pid_pl, 12'(m_pid[0]));
        end
    endtask

    task automatic test_integ();
        rider_off = 1'b0; vld = 1'b1; ptch = 16'sh0040; ptch_rt = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (pid_aw !== 12'(m_pid[0]) || pid_pl !== 12'(m_pid[1])) begin
                errors++;
                $display("FAIL integ_ramp: edge %0d pid=%h/%h, want %h", i, pid_aw, pid_pl, 12'(m_pid[0]));
            end
        end
        checks++;
        if (pid_aw !== 12'h349 || dut_aw.integ_q !== 18'sd640 || dut_pl.integ_q !== 18'sd640) begin
            errors++;
            $display("FAIL integ_10: pid=%h integ=%0d/%0d, want 349 640", pid_aw, dut_aw.integ_q, dut_pl.integ_q);
        end
        rider_off = 1'b1;
        step();
        rider_off = 1'b0; vld = 1'b0;
        step();
        checks++;
        if (pid_aw !== 12'h340 || pid_pl !== 12'h340 || dut_aw.integ_q !== 18'sd0) begin
            errors++;
            $display("FAIL integ_clear: pid=%h/%h integ=%0d, want 340 0", pid_aw, pid_pl, dut_aw.integ_q);
        end
    endtask

    task automatic test_windup();
        ptch = 16'sh03FF; ptch_rt = '0; vld = 1'b1; rider_off = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if (pid_aw !== 12'(m_pid[0]) || pid_pl !== 12'(m_pid[1]) || sat_aw !== m_sat[0] || sat_pl !== m_sat[1]) begin
                errors++;
                $display("FAIL windup: edge %0d pid=%h/%h sat=%b/%b, want %h/%h %b/%b", i, pid_aw, pid_pl,
                         sat_aw, sat_pl, 12'(m_pid[0]), 12'(m_pid[1]), m_sat[0], m_sat[1]);
            end
            checks++;
            if (int'(dut_aw.integ_q) != m_integ[0] || int'(dut_pl.integ_q) != m_integ[1]) begin
                errors++;
                $display("FAIL windup_integ: edge %0d integ=%0d/%0d, want %0d/%0d", i,
                         dut_aw.integ_q, dut_pl.integ_q, m_integ[0], m_integ[1]);
            end
        end
        checks++;
        if (pid_aw !== 12'h7FF || sat_aw !== 1'b1 || dut_aw.integ_q !== 18'sd0) begin
            errors++;
            $display("FAIL aw_freeze: pid=%h sat=%b integ=%0d, want 7FF 1 0", pid_aw, sat_aw, dut_aw.integ_q);
        end
        checks++;
        if (dut_pl.integ_q !== 18'sh1FFFF) begin
            errors++;
            $display("FAIL integ_clamp: integ=%h, want 1FFFF", dut_pl.integ_q);
        end
    endtask

    task automatic test_neg();
        int cnt;
        ptch = 16'shFF00; rider_off = 1'b1; vld = 1'b0;
        step();
        step();
        checks++;
        if (pid_aw !== 12'h800 || pid_pl !== 12'h800 || sat_aw !== 1'b1 || sat_pl !== 1'b1) begin
            errors++;
            $display("FAIL neg_rail: pid=%h/%h sat=%b/%b, want 800 1", pid_aw, pid_pl, sat_aw, sat_pl);
        end
        rider_off = 1'b0; ptch = 16'shFF80; cnt = 0;
        for (int i = 0; i < 60; i++) begin
            vld = 1'($urandom_range(0, 1));
            if (vld) cnt++;
            step();
            checks++;
            if (pid_aw !== 12'(m_pid[0]) || pid_pl !== 12'(m_pid[1]) || sat_aw !== m_sat[0]) begin
                errors++;
                $display("FAIL neg_pid: edge %0d pid=%h/%h, want %h/%h", i, pid_aw, pid_pl, 12'(m_pid[0]), 12'(m_pid[1]));
            end
        end
        checks++;
        if (int'(dut_aw.integ_q) != -128 * cnt || int'(dut_pl.integ_q) != -128 * cnt) begin
            errors++;
            $display("FAIL neg_integ: integ=%0d/%0d, want %0d", dut_aw.integ_q, dut_pl.integ_q, -128 * cnt);
        end
    endtask

    task automatic test_softstart();
        vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            checks++;
            if (ss_aw !== 8'(exp_ss()) || ss_pl !== 8'(exp_ss())) begin
                errors++;
                $display("FAIL ss_count: clk %0d ss=%h/%h, want %h", i, ss_aw, ss_pl, 8'(exp_ss()));
            end
            if (i == 16 || i == 4080 || i == 5000) begin
                checks++;
                if (ss_aw !== ((i == 16) ? 8'h01 : 8'hFF)) begin
                    errors++;
                    $display("FAIL ss_mark: clk %0d ss=%h, want %h", i, ss_aw, (i == 16) ? 8'h01 : 8'hFF);
                end
            end
        end
        pwr_up = 1'b0;
        step();
        checks++;
        if (ss_aw !== 8'h00 || ss_pl !== 8'h00) begin
            errors++;
            $display("FAIL ss_clear: ss=%h/%h, want 00", ss_aw, ss_pl);
        end
        pwr_up = 1'b1; vld = 1'b1; ptch = 16'sh0040;
        for (int i = 0; i < 40; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (pid_aw !== 12'h000 || pid_pl !== 12'h000 || sat_aw !== 1'b0 || ss_aw !== 8'h00 ||
            dut_aw.integ_q !== 18'sd0 || dut_pl.integ_q !== 18'sd0) begin
            errors++;
            $display("FAIL mid_reset: pid=%h/%h sat=%b ss=%h integ=%0d/%0d, want all 0",
                     pid_aw, pid_pl, sat_aw, ss_aw, dut_aw.integ_q, dut_pl.integ_q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rider_off = ($urandom_range(0, 29) == 0);
            vld       = 1'($urandom_range(0, 1));
            pwr_up    = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0)
                ptch = 16'($urandom);
            else
                ptch = 16'(int'($urandom_range(0, 1400)) - 700);
            ptch_rt = 16'($urandom);
            step();
            checks++;
            if (pid_aw !== 12'(m_pid[0]) || pid_pl !== 12'(m_pid[1]) || sat_aw !== m_sat[0] || sat_pl !== m_sat[1]) begin
                errors++;
                $display("FAIL rand_out: cyc %0d pid=%h/%h sat=%b/%b, want %h/%h %b/%b", i, pid_aw, pid_pl,
                         sat_aw, sat_pl, 12'(m_pid[0]), 12'(m_pid[1]), m_sat[0], m_sat[1]);
            end
            checks++;
            if (int'(dut_aw.integ_q) != m_integ[0] || int'(dut_pl.integ_q) != m_integ[1] ||
                ss_aw !== 8'(exp_ss()) || ss_pl !== 8'(exp_ss())) begin
                errors++;
                $display("FAIL rand_state: cyc %0d integ=%0d/%0d ss=%h/%h, want %0d/%0d %h", i,
                         dut_aw.integ_q, dut_pl.integ_q, ss_aw, ss_pl, m_integ[0], m_integ[1], 8'(exp_ss()));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_integ[k] = 0;
            m_pid[k]   = 0;
            m_sat[k]   = 1'b0;
        end
        m_on = 0;
        #2;
        test_reset();
        test_p_d();
        test_integ();
        test_windup();
        test_neg();
        test_softstart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
